// File: rtl/wb_xbar_arb.sv
// Shared-bus Wishbone interconnect: NUM_M masters arbitrated round-robin onto
// one bus, NUM_S slaves selected by base/mask address windows. Unmapped
// accesses are answered by a built-in error slave and a stalled slave is
// cut off by a response timeout.

// One address window compare; one instance per slave.
module wb_xbar_win #(
  parameter logic [31:0] BASE = '0,
  parameter logic [31:0] MASK = '0
) (
  input  logic [31:0] adr,
  output logic        hit
);
  assign hit = ((adr & MASK) == BASE);
endmodule

module wb_xbar_arb #(
  parameter int                  NUM_M   = 4,
  parameter int                  NUM_S   = 8,
  parameter int                  DW      = 32,
  parameter logic [NUM_S*32-1:0] S_BASE  = '0,
  parameter logic [NUM_S*32-1:0] S_MASK  = '0,
  parameter int                  TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_M*32-1:0]     m_adr_i,
  input  logic [NUM_M*DW-1:0]     m_dat_i,
  input  logic [NUM_M*DW/8-1:0]   m_sel_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  output logic [DW-1:0]           m_dat_o,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic [NUM_M-1:0]        m_rty_o,
  output logic [31:0]             s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [DW/8-1:0]         s_sel_o,
  output logic                    s_we_o,
  output logic [NUM_S-1:0]        s_cyc_o,
  output logic [NUM_S-1:0]        s_stb_o,
  input  logic [NUM_S*DW-1:0]     s_dat_i,
  input  logic [NUM_S-1:0]        s_ack_i,
  input  logic [NUM_S-1:0]        s_err_i,
  input  logic [NUM_S-1:0]        s_rty_i,
  output logic [NUM_M-1:0]        gnt_o
);
  localparam int SW = DW / 8;
  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nx;
  logic [NUM_M-1:0]  gnt, gnt_nx;
  logic [MW-1:0]     last, last_nx, pick;
  logic              found;

  logic              gcyc, gstb, gwe;
  logic [31:0]       gadr;
  logic [DW-1:0]     gdat;
  logic [SW-1:0]     gsel;

  logic [NUM_S-1:0]  hit, sel;
  logic              busy, hit_any, taken;
  logic              sack, serr, srty, resp;
  logic [DW-1:0]     rdat;

  logic [CW-1:0]     cnt;
  logic              to_hit, def_err;
  logic              ack, err, rty;

  assign busy = (state == BUSY);

  // Round-robin pick: first requester strictly after the last owner, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      if (!found && m_cyc_i[(int'(last) + i) % NUM_M]) begin
        found = 1'b1;
        pick  = MW'((int'(last) + i) % NUM_M);
      end
    end
  end

  // Next-state: grant registered out of IDLE, held until the owner drops cyc.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    unique case (state)
      IDLE: if (found) begin
        state_nx     = BUSY;
        gnt_nx       = '0;
        gnt_nx[pick] = 1'b1;
        last_nx      = pick;
      end
      BUSY: if (!gcyc) begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, grant and last-owner registers; master 0 wins first after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= MW'(NUM_M - 1);
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
    end
  end

  // Owner's bus signals; grant is all-zero in IDLE so these idle at 0.
  always_comb begin
    gcyc = 1'b0;
    gstb = 1'b0;
    gwe  = 1'b0;
    gadr = '0;
    gdat = '0;
    gsel = '0;
    for (int m = 0; m < NUM_M; m++) begin
      if (gnt[m]) begin
        gcyc = m_cyc_i[m];
        gstb = m_stb_i[m];
        gwe  = m_we_i[m];
        gadr = m_adr_i[32*m +: 32];
        gdat = m_dat_i[DW*m +: DW];
        gsel = m_sel_i[SW*m +: SW];
      end
    end
  end

  for (genvar k = 0; k < NUM_S; k++) begin : g_win
    wb_xbar_win #(
      .BASE (S_BASE[32*k +: 32]),
      .MASK (S_MASK[32*k +: 32])
    ) u_win (
      .adr (gadr),
      .hit (hit[k])
    );
  end

  // Lowest-index window wins on overlap; nothing selected outside BUSY.
  always_comb begin
    sel   = '0;
    taken = 1'b0;
    for (int k = 0; k < NUM_S; k++) begin
      if (busy && hit[k] && !taken) begin
        sel[k] = 1'b1;
        taken  = 1'b1;
      end
    end
  end

  assign hit_any = taken;
  assign sack    = |(sel & s_ack_i);
  assign serr    = |(sel & s_err_i);
  assign srty    = |(sel & s_rty_i);
  assign resp    = sack | serr | srty;

  // Read data from the selected slave, zero when nothing is selected.
  always_comb begin
    rdat = '0;
    for (int k = 0; k < NUM_S; k++) begin
      if (sel[k]) rdat = s_dat_i[DW*k +: DW];
    end
  end

  assign to_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));

  // Response timeout: counts stalled strobe cycles, saturating; clears on fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (gstb && hit_any && !resp && !to_hit) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
    end else
      cnt <= '0;
  end

  // Default slave: error one cycle after an unmapped strobe, then every other cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) def_err <= 1'b0;
    else          def_err <= gstb && !hit_any && !def_err;
  end

  // One response per cycle, ack > err > rty; a real response beats the timeout.
  assign ack = gstb & sack;
  assign err = gstb & ~sack & (serr | (hit_any & to_hit & ~resp) | (~hit_any & def_err));
  assign rty = gstb & srty & ~sack & ~serr;

  assign m_ack_o = {NUM_M{ack}} & gnt;
  assign m_err_o = {NUM_M{err}} & gnt;
  assign m_rty_o = {NUM_M{rty}} & gnt;
  assign m_dat_o = rdat;

  assign s_adr_o = gadr;
  assign s_dat_o = gdat;
  assign s_sel_o = gsel;
  assign s_we_o  = gwe;
  assign s_cyc_o = {NUM_S{gcyc}} & sel;
  assign s_stb_o = {NUM_S{gstb & ~to_hit}} & sel;
  assign gnt_o   = gnt;

endmodule

// File: tb/tb_wb_xbar_arb.sv
// Bench for wb_xbar_arb: directed vector table, multi-cycle sequences for
// arbitration / default slave / timeout / reset, then random traffic against
// a transaction-level reference model.
module tb_wb_xbar_arb;
  localparam int NM = 4;
  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [NS*32-1:0] BASES = {32'h2000_0000, 32'h0000_0000, 32'h2000_0000, 32'h1000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hF000_0000, 32'hFFFF_0000, 32'hFF00_0000, 32'hF000_0000};

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NM*32-1:0]  m_adr_i, m_dat_i;
  logic [NM*4-1:0]   m_sel_i;
  logic [NM-1:0]     m_we_i, m_cyc_i, m_stb_i;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o, gnt_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic [NS*32-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i, s_err_i, s_rty_i;

  wb_xbar_arb #(.NUM_M(NM), .NUM_S(NS), .DW(32), .S_BASE(BASES), .S_MASK(MASKS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        stb;
    logic [3:0]  ack, err, rty;
    logic [3:0]  e_cyc, e_stb, e_ack, e_err, e_rty;
    logic [31:0] e_dat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] mbase[NS], mmask[NS], pool[5];
  int          owner, last, age, run, rsel, nsel, r;
  logic        rc, rs, fire, anyr, e_we;
  logic [3:0]  e_gnt, e_cyc, e_stb, e_ack, e_err, e_rty, e_sel;
  logic [31:0] e_dat, e_adr, e_wd;
  vec_t        vt[9];
  int          ord[4];

  task automatic chk_n(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_m(input int m, input logic c, input logic s, input logic [31:0] a);
    m_cyc_i[m]       = c;
    m_stb_i[m]       = s;
    m_adr_i[32*m +: 32] = a;
  endtask

  task automatic clr_resp;
    s_ack_i = '0;
    s_err_i = '0;
    s_rty_i = '0;
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++)
      if ((a & mmask[k]) == mbase[k]) return k;
    return -1;
  endfunction

  initial begin
    mbase[0] = 32'h1000_0000; mmask[0] = 32'hF000_0000;
    mbase[1] = 32'h2000_0000; mmask[1] = 32'hFF00_0000;
    mbase[2] = 32'h0000_0000; mmask[2] = 32'hFFFF_0000;
    mbase[3] = 32'h2000_0000; mmask[3] = 32'hF000_0000;
    pool[0] = 32'h1000_0040; pool[1] = 32'h2000_1234; pool[2] = 32'h2500_0000;
    pool[3] = 32'h0000_0010; pool[4] = 32'h9000_0000;
    //         adr           stb  ack     err     rty     cyc     stb     ack     err     rty     dat
    vt[0] = '{32'h1000_0040, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 32'hC0DE_0000};
    vt[1] = '{32'h2000_1234, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 32'hC0DE_0001};
    vt[2] = '{32'h2500_0000, 1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0010, 4'b0000, 4'b0000, 32'hC0DE_0003};
    vt[3] = '{32'h2500_0000, 1'b1, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 32'hC0DE_0003};
    vt[4] = '{32'h1000_0000, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 32'hC0DE_0000};
    vt[5] = '{32'h1000_0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'hC0DE_0000};
    vt[6] = '{32'h9000_0000, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000};
    vt[7] = '{32'h2000_1234, 1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 32'hC0DE_0001};
    vt[8] = '{32'h0000_0010, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 32'hC0DE_0002};
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 0;

    // reset holds everything quiet even with requests and responses present
    reset_n = 1'b0;
    m_adr_i = {NM{32'h1000_0000}}; m_dat_i = '0; m_sel_i = '1; m_we_i = '0;
    m_cyc_i = '1; m_stb_i = '1;
    s_ack_i = '1; s_err_i = '0; s_rty_i = '0;
    s_dat_i = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    #3;
    chk_n("rst_gnt", gnt_o, 4'b0000);
    chk_n("rst_scyc", s_cyc_o, 4'b0000);
    chk_n("rst_sstb", s_stb_o, 4'b0000);
    chk_n("rst_mack", m_ack_o, 4'b0000);
    chk_w("rst_mdat", m_dat_o, 32'h0);
    chk_w("rst_sadr", s_adr_o, 32'h0);
    step; step;
    chk_n("rst_gnt_held", gnt_o, 4'b0000);
    m_cyc_i = '0; m_stb_i = '0; clr_resp;
    reset_n = 1'b1;

    // single read from master 0 to slave 2, acked two cycles after strobe
    step;
    set_m(0, 1'b1, 1'b1, 32'h0000_0010);
    s_dat_i[32*2 +: 32] = 32'hDEAD_BEEF;
    settle;
    chk_n("rd_arb_latency", gnt_o, 4'b0000);
    step; settle;
    chk_n("rd_gnt", gnt_o, 4'b0001);
    chk_n("rd_scyc", s_cyc_o, 4'b0100);
    chk_n("rd_sstb", s_stb_o, 4'b0100);
    chk_w("rd_sadr", s_adr_o, 32'h0000_0010);
    chk_n("rd_noack", m_ack_o, 4'b0000);
    step; step;
    s_ack_i[2] = 1'b1;
    settle;
    chk_n("rd_ack", m_ack_o, 4'b0001);
    chk_w("rd_dat", m_dat_o, 32'hDEAD_BEEF);
    step;
    clr_resp; set_m(0, 1'b0, 1'b0, 32'h0);
    s_dat_i[32*2 +: 32] = 32'hC0DE_0002;
    step; settle;
    chk_n("rd_release", gnt_o, 4'b0000);

    // vector table with master 1 holding the bus
    set_m(1, 1'b1, 1'b0, 32'h1000_0000);
    step; settle;
    chk_n("tbl_gnt", gnt_o, 4'b0010);
    for (int i = 0; i < 9; i++) begin
      m_adr_i[32*1 +: 32] = vt[i].adr;
      m_stb_i[1] = vt[i].stb;
      s_ack_i = vt[i].ack; s_err_i = vt[i].err; s_rty_i = vt[i].rty;
      settle;
      chk_n($sformatf("vec%0d_scyc", i), s_cyc_o, vt[i].e_cyc);
      chk_n($sformatf("vec%0d_sstb", i), s_stb_o, vt[i].e_stb);
      chk_n($sformatf("vec%0d_ack", i), m_ack_o, vt[i].e_ack);
      chk_n($sformatf("vec%0d_err", i), m_err_o, vt[i].e_err);
      chk_n($sformatf("vec%0d_rty", i), m_rty_o, vt[i].e_rty);
      chk_w($sformatf("vec%0d_dat", i), m_dat_o, vt[i].e_dat);
      m_stb_i[1] = 1'b0; clr_resp;
      step;
    end
    set_m(1, 1'b0, 1'b0, 32'h0);
    step; step;

    // round robin 0,1,2,0 from a fresh reset
    reset_n = 1'b0;
    step;
    reset_n = 1'b1;
    for (int m = 0; m < 3; m++) set_m(m, 1'b1, 1'b0, 32'h1000_0000);
    settle;
    chk_n("rr_latency", gnt_o, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      step; settle;
      chk_n($sformatf("rr_gnt%0d", k), gnt_o, 4'(1 << ord[k]));
      m_stb_i[ord[k]] = 1'b1; s_ack_i[0] = 1'b1;
      settle;
      chk_n($sformatf("rr_ack%0d", k), m_ack_o, 4'(1 << ord[k]));
      step;
      clr_resp; set_m(ord[k], 1'b0, 1'b0, 32'h1000_0000);
      settle;
      chk_n($sformatf("rr_drop%0d", k), gnt_o, 4'(1 << ord[k]));
      step; settle;
      chk_n($sformatf("rr_idle%0d", k), gnt_o, 4'b0000);
      if (k == 0) set_m(0, 1'b1, 1'b0, 32'h1000_0000);
    end

    // master 1 burst of 4 beats is not preempted by master 0
    set_m(1, 1'b1, 1'b0, 32'h1000_0000);
    step; settle;
    chk_n("burst_gnt", gnt_o, 4'b0010);
    set_m(0, 1'b1, 1'b0, 32'h1000_0000);
    for (int b = 0; b < 4; b++) begin
      m_stb_i[1] = 1'b1; s_ack_i[0] = 1'b1;
      settle;
      chk_n($sformatf("burst_gnt_b%0d", b), gnt_o, 4'b0010);
      chk_n($sformatf("burst_ack_b%0d", b), m_ack_o, 4'b0010);
      step;
    end
    clr_resp; set_m(1, 1'b0, 1'b0, 32'h0);
    settle;
    chk_n("burst_hold", gnt_o, 4'b0010);
    step; settle;
    chk_n("burst_idle", gnt_o, 4'b0000);
    step; settle;
    chk_n("burst_next", gnt_o, 4'b0001);

    // unmapped access: default slave error one cycle later, then every 2 cycles
    set_m(0, 1'b1, 1'b1, 32'h9000_0000);
    settle;
    chk_n("unm_scyc", s_cyc_o, 4'b0000);
    chk_n("unm_err0", m_err_o, 4'b0000);
    step; settle;
    chk_n("unm_err1", m_err_o, 4'b0001);
    chk_n("unm_ack1", m_ack_o, 4'b0000);
    chk_w("unm_dat", m_dat_o, 32'h0);
    step; settle;
    chk_n("unm_err2", m_err_o, 4'b0000);
    step; settle;
    chk_n("unm_err3", m_err_o, 4'b0001);
    m_stb_i[0] = 1'b0;
    step;

    // timeout: error exactly TO cycles after strobe, strobe cut that cycle
    set_m(0, 1'b1, 1'b1, 32'h1000_0000);
    for (int i = 0; i < TO; i++) begin
      settle;
      chk_n($sformatf("to_quiet%0d", i), m_err_o, 4'b0000);
      step;
    end
    settle;
    chk_n("to_err", m_err_o, 4'b0001);
    chk_n("to_sstb", s_stb_o, 4'b0000);
    step; settle;
    chk_n("to_cleared", m_err_o, 4'b0000);
    chk_n("to_sstb_back", s_stb_o, 4'b0001);
    m_stb_i[0] = 1'b0;
    step;
    // late ack on the timeout cycle wins
    m_stb_i[0] = 1'b1;
    repeat (TO) step;
    s_ack_i[0] = 1'b1;
    settle;
    chk_n("to_late_ack", m_ack_o, 4'b0001);
    chk_n("to_late_noerr", m_err_o, 4'b0000);
    clr_resp;
    step;

    // asynchronous reset mid-transfer
    settle;
    chk_n("mid_pre_scyc", s_cyc_o, 4'b0001);
    reset_n = 1'b0;
    #1;
    chk_n("mid_gnt", gnt_o, 4'b0000);
    chk_n("mid_scyc", s_cyc_o, 4'b0000);
    chk_n("mid_sstb", s_stb_o, 4'b0000);
    set_m(1, 1'b1, 1'b0, 32'h1000_0000);
    step;
    reset_n = 1'b1;
    settle;
    chk_n("mid_idle", gnt_o, 4'b0000);
    step; settle;
    chk_n("mid_first", gnt_o, 4'b0001);
    m_cyc_i = '0; m_stb_i = '0;

    // random traffic vs reference model, from a clean reset
    step;
    reset_n = 1'b0;
    step;
    reset_n = 1'b1;
    owner = -1; last = NM - 1; age = 0; run = 0;
    for (int n = 0; n < 1500; n++) begin
      step;
      for (int m = 0; m < NM; m++) begin
        rc = (m == owner) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1);
        m_cyc_i[m] = rc;
        m_stb_i[m] = rc && ($urandom_range(0, 7) != 0);
        r = $urandom_range(0, 5);
        m_adr_i[32*m +: 32] = (r == 5) ? $urandom : pool[r];
        m_dat_i[32*m +: 32] = $urandom;
        m_sel_i[4*m +: 4]   = 4'($urandom);
        m_we_i[m]           = 1'($urandom);
      end
      for (int k = 0; k < NS; k++) begin
        s_ack_i[k] = ($urandom_range(0, 15) == 0);
        s_err_i[k] = ($urandom_range(0, 15) == 0);
        s_rty_i[k] = ($urandom_range(0, 15) == 0);
        s_dat_i[32*k +: 32] = $urandom;
      end
      settle;
      e_gnt = '0; e_cyc = '0; e_stb = '0; e_ack = '0; e_err = '0; e_rty = '0;
      e_dat = '0; e_adr = '0; e_wd = '0; e_sel = '0; e_we = 1'b0;
      rc = 1'b0; rs = 1'b0; rsel = -1; fire = 1'b0; anyr = 1'b0;
      if (owner >= 0) begin
        e_gnt[owner] = 1'b1;
        rc    = m_cyc_i[owner];
        rs    = m_stb_i[owner];
        e_adr = m_adr_i[32*owner +: 32];
        e_wd  = m_dat_i[32*owner +: 32];
        e_sel = m_sel_i[4*owner +: 4];
        e_we  = m_we_i[owner];
        rsel  = decode(e_adr);
        if (rsel >= 0) begin
          fire = (age == TO);
          anyr = s_ack_i[rsel] | s_err_i[rsel] | s_rty_i[rsel];
          e_cyc[rsel] = rc;
          e_stb[rsel] = rs && !fire;
          e_dat = s_dat_i[32*rsel +: 32];
          if (rs) begin
            if (s_ack_i[rsel])                       e_ack[owner] = 1'b1;
            else if (s_err_i[rsel] || (fire && !anyr)) e_err[owner] = 1'b1;
            else if (s_rty_i[rsel])                  e_rty[owner] = 1'b1;
          end
        end else if (rs && (run % 2 == 1)) begin
          e_err[owner] = 1'b1;
        end
      end
      chk_n("rnd_gnt", gnt_o, e_gnt);
      chk_n("rnd_scyc", s_cyc_o, e_cyc);
      chk_n("rnd_sstb", s_stb_o, e_stb);
      chk_n("rnd_ack", m_ack_o, e_ack);
      chk_n("rnd_err", m_err_o, e_err);
      chk_n("rnd_rty", m_rty_o, e_rty);
      chk_w("rnd_mdat", m_dat_o, e_dat);
      chk_w("rnd_sadr", s_adr_o, e_adr);
      chk_w("rnd_sdat", s_dat_o, e_wd);
      chk_n("rnd_ssel", s_sel_o, e_sel);
      chk_n("rnd_swe", {3'b000, s_we_o}, {3'b000, e_we});
      if (owner < 0) begin
        nsel = -1;
        for (int i = 1; i <= NM; i++)
          if (nsel < 0 && m_cyc_i[(last + i) % NM]) nsel = (last + i) % NM;
        age = 0; run = 0;
        if (nsel >= 0) begin
          owner = nsel;
          last  = nsel;
        end
      end else begin
        age = (rs && rsel >= 0 && !anyr && !fire) ? age + 1 : 0;
        run = (rs && rsel < 0) ? run + 1 : 0;
        if (!rc) owner = -1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
